// File: rtl/reg_mem_seq.sv
// reg_mem_seq: sequences single-register LOAD/STORE transfers between a bank of
// tri-state registers and a memory with a fixed read latency.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for a command, cmd_ready high
// S_STORE   | register drives the bus (rM), memory write strobe asserted
// S_RD_REQ  | memory read strobe asserted, address presented
// S_RD_WAIT | waiting out the remaining read latency (down-counter)
// S_CAPTURE | register loads from the bus (wM), collision sampled
// S_DONE    | one-cycle completion pulse, err reported here
//
// Every output is a register written alongside the state, so each output
// reflects the state it belongs to from the edge that entered that state.

module reg_mem_seq #(
  parameter int NREG    = 8,
  parameter int AW      = 8,
  parameter int MEM_LAT = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_op,
  input  logic [2:0]      cmd_sel,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [NREG-1:0] bus_wr,
  output logic [NREG-1:0] wM,
  output logic [NREG-1:0] rM,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_re,
  output logic            mem_we,
  output logic            busy,
  output logic            done,
  output logic            err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STORE   = 3'd1,
    S_RD_REQ  = 3'd2,
    S_RD_WAIT = 3'd3,
    S_CAPTURE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [3:0] NREG_L = 4'(NREG);
  // RD_WAIT lasts MEM_LAT-1 cycles: preset MEM_LAT-2 and leave when it reads 0.
  localparam logic [3:0] WAIT_PRESET = (MEM_LAT >= 2) ? 4'(MEM_LAT - 2) : 4'd0;

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              op_q;
  logic [2:0]        sel_q;
  logic [AW-1:0]     addr_q;
  logic [NREG-1:0]   wm_q;
  logic [NREG-1:0]   rm_q;
  logic [AW-1:0]     mem_addr_q;
  logic              mem_re_q;
  logic              mem_we_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic              ready_q;

  logic              accept;
  logic              sel_invalid;
  logic [NREG-1:0]   cmd_sel_oh;
  logic [NREG-1:0]   lat_sel_oh;
  logic              collide;

  // Select decode without indexing by a possibly out-of-range value.
  function automatic logic [NREG-1:0] sel_onehot(input logic [2:0] s);
    logic [NREG-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) begin
      if (s == 3'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Command acceptance and register-select decode for the incoming and latched command.
  always_comb begin
    accept      = cmd_valid & ready_q;
    sel_invalid = ({1'b0, cmd_sel} >= NREG_L);
    cmd_sel_oh  = sel_onehot(cmd_sel);
    lat_sel_oh  = sel_onehot(sel_q);
    collide     = |(bus_wr & lat_sel_oh);
  end

  // Sequencer: state, wait counter, latched command and all registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      op_q       <= 1'b0;
      sel_q      <= 3'd0;
      addr_q     <= '0;
      wm_q       <= '0;
      rm_q       <= '0;
      mem_addr_q <= '0;
      mem_re_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      wm_q       <= '0;
      rm_q       <= '0;
      mem_addr_q <= '0;
      mem_re_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q   <= cmd_op;
            sel_q  <= cmd_sel;
            addr_q <= cmd_addr;
            if (sel_invalid) begin
              // Nothing is strobed for a select outside the bank.
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (cmd_op) begin
              state_q    <= S_STORE;
              rm_q       <= cmd_sel_oh;
              mem_we_q   <= 1'b1;
              mem_addr_q <= cmd_addr;
            end else begin
              state_q    <= S_RD_REQ;
              mem_re_q   <= 1'b1;
              mem_addr_q <= cmd_addr;
            end
          end else begin
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end

        S_STORE: begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end

        S_RD_REQ: begin
          mem_addr_q <= addr_q;
          if (MEM_LAT == 1) begin
            state_q <= S_CAPTURE;
            wm_q    <= lat_sel_oh;
          end else begin
            state_q <= S_RD_WAIT;
            cnt_q   <= WAIT_PRESET;
          end
        end

        S_RD_WAIT: begin
          mem_addr_q <= addr_q;
          if (cnt_q == 4'd0) begin
            state_q <= S_CAPTURE;
            wm_q    <= lat_sel_oh;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        S_CAPTURE: begin
          // The register lets a datapath write win, so the loaded value is lost.
          state_q <= S_DONE;
          done_q  <= 1'b1;
          err_q   <= ~op_q & collide;
        end

        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign wM        = wm_q;
  assign rM        = rm_q;
  assign mem_addr  = mem_addr_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_reg_mem_seq.sv
// Bench for reg_mem_seq: two instances (NREG=8/MEM_LAT=2 and NREG=4/MEM_LAT=1)
// share one stimulus set; a transfer-level model predicts every output cycle.

module tb_reg_mem_seq;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_op = 1'b0;
  logic [2:0] cmd_sel = 3'd0;
  logic [7:0] cmd_addr = 8'd0;
  logic [7:0] bus_wr = 8'd0;
  logic       use_a = 1'b1;

  logic       a_ready, a_re, a_we, a_busy, a_done, a_err;
  logic [7:0] a_wm, a_rm, a_addr;
  logic       b_ready, b_re, b_we, b_busy, b_done, b_err;
  logic [3:0] b_wm, b_rm;
  logic [7:0] b_addr;

  int total = 0;
  int bad   = 0;

  localparam logic [29:0] IDLE_V  = 30'h2000_0000;
  localparam logic [29:0] RESET_V = 30'h0;

  always #5 clk = ~clk;

  reg_mem_seq #(.NREG(8), .AW(8), .MEM_LAT(2)) dut_a (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid & use_a), .cmd_ready(a_ready),
    .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .bus_wr(bus_wr),
    .wM(a_wm), .rM(a_rm), .mem_addr(a_addr), .mem_re(a_re), .mem_we(a_we),
    .busy(a_busy), .done(a_done), .err(a_err)
  );

  reg_mem_seq #(.NREG(4), .AW(8), .MEM_LAT(1)) dut_b (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid & ~use_a), .cmd_ready(b_ready),
    .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .bus_wr(bus_wr[3:0]),
    .wM(b_wm), .rM(b_rm), .mem_addr(b_addr), .mem_re(b_re), .mem_we(b_we),
    .busy(b_busy), .done(b_done), .err(b_err)
  );

  // {ready, busy, done, err, re, we, addr[7:0], wM[7:0], rM[7:0]}
  function automatic logic [29:0] observe();
    if (use_a)
      return {a_ready, a_busy, a_done, a_err, a_re, a_we, a_addr, a_wm, a_rm};
    return {b_ready, b_busy, b_done, b_err, b_re, b_we, b_addr, 4'b0, b_wm, 4'b0, b_rm};
  endfunction

  function automatic int ncyc(input bit op, input int sel, input int nreg, input int lat);
    if (sel >= nreg) return 1;
    if (op) return 2;
    return lat + 2;
  endfunction

  // Expected outputs k cycles after the accepting edge (k = 1 is the first busy cycle).
  function automatic logic [29:0] model(input bit op, input int sel, input logic [7:0] addr,
                                        input logic [7:0] bw, input int k,
                                        input int nreg, input int lat);
    logic       rdy, bsy, dn, er, re, we;
    logic [7:0] ad, wm, rm, one;
    one = 8'd1;
    rdy = 1'b0; bsy = 1'b1; dn = 1'b0; er = 1'b0; re = 1'b0; we = 1'b0;
    ad = 8'd0; wm = 8'd0; rm = 8'd0;
    if (k > ncyc(op, sel, nreg, lat)) begin
      rdy = 1'b1; bsy = 1'b0;
    end else if (sel >= nreg) begin
      dn = 1'b1; er = 1'b1;
    end else if (op) begin
      if (k == 1) begin rm = one << sel; we = 1'b1; ad = addr; end
      else dn = 1'b1;
    end else begin
      if (k == 1) begin re = 1'b1; ad = addr; end
      else if (k <= lat) ad = addr;
      else if (k == lat + 1) begin wm = one << sel; ad = addr; end
      else begin dn = 1'b1; er = bw[sel]; end
    end
    return {rdy, bsy, dn, er, re, we, ad, wm, rm};
  endfunction

  task automatic check(input string tag, input logic [29:0] exp);
    logic [29:0] o;
    o = observe();
    total++;
    assert (o === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in an IDLE cycle; returns in the IDLE cycle after done.
  // hold keeps cmd_valid high so the next call is accepted back to back.
  task automatic run_cmd(input bit op, input int sel, input logic [7:0] addr,
                         input logic [7:0] bw, input bit hold,
                         input int nreg, input int lat, input string tag);
    int n;
    n = ncyc(op, sel, nreg, lat);
    check({tag, "/idle"}, IDLE_V);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_sel   = 3'(sel);
    cmd_addr  = addr;
    bus_wr    = 8'($urandom);
    for (int k = 1; k <= n; k++) begin
      tick();
      cmd_valid = 1'b1;
      cmd_op    = 1'($urandom);
      cmd_sel   = 3'($urandom);
      cmd_addr  = 8'($urandom);
      if (!op && sel < nreg && k == lat + 1) bus_wr = bw;
      else bus_wr = 8'($urandom);
      check($sformatf("%s/k%0d", tag, k), model(op, sel, addr, bw, k, nreg, lat));
    end
    if (!hold) cmd_valid = 1'b0;
    tick();
  endtask

  initial begin
    #3;
    check("reset_a", RESET_V);
    use_a = 1'b0;
    check("reset_b", RESET_V);
    use_a = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Instance A: NREG=8, MEM_LAT=2
    run_cmd(1'b1, 3, 8'h25, 8'h00, 1'b0, 8, 2, "store_s3");
    run_cmd(1'b0, 5, 8'h80, 8'h00, 1'b0, 8, 2, "load_s5");
    run_cmd(1'b0, 6, 8'h11, 8'h40, 1'b0, 8, 2, "collide_s6");
    run_cmd(1'b0, 6, 8'h12, 8'h01, 1'b0, 8, 2, "nocollide_s6");
    run_cmd(1'b1, 7, 8'hFF, 8'h00, 1'b0, 8, 2, "store_s7");
    run_cmd(1'b0, 0, 8'h00, 8'hFF, 1'b0, 8, 2, "load_s0_coll");
    run_cmd(1'b1, 0, 8'h33, 8'h00, 1'b1, 8, 2, "b2b_first");
    run_cmd(1'b0, 1, 8'h44, 8'h00, 1'b1, 8, 2, "b2b_second");
    run_cmd(1'b1, 2, 8'h55, 8'h00, 1'b0, 8, 2, "b2b_third");

    // Reset dropped while waiting on the memory read
    check("rst_pre/idle", IDLE_V);
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_sel = 3'd2; cmd_addr = 8'h5A;
    tick();
    cmd_valid = 1'b0;
    check("rst_rdreq", model(1'b0, 2, 8'h5A, 8'h00, 1, 8, 2));
    tick();
    check("rst_rdwait", model(1'b0, 2, 8'h5A, 8'h00, 2, 8, 2));
    #2;
    rstn = 1'b0;
    #1;
    check("rst_async", RESET_V);
    tick();
    check("rst_held", RESET_V);
    @(negedge clk);
    rstn = 1'b1;
    tick();
    run_cmd(1'b1, 4, 8'hC3, 8'h00, 1'b0, 8, 2, "post_rst_store");

    for (int i = 0; i < 40; i++) begin
      run_cmd(1'($urandom), int'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
              (i != 39) && ($urandom_range(0, 1) == 1), 8, 2, $sformatf("rand_a%0d", i));
    end

    // Instance B: NREG=4, MEM_LAT=1
    use_a = 1'b0;
    run_cmd(1'b0, 3, 8'h80, 8'h00, 1'b0, 4, 1, "b_load_s3");
    run_cmd(1'b0, 2, 8'h81, 8'h04, 1'b0, 4, 1, "b_collide_s2");
    run_cmd(1'b0, 6, 8'h90, 8'h00, 1'b0, 4, 1, "b_bad_s6");
    run_cmd(1'b1, 4, 8'h91, 8'h00, 1'b0, 4, 1, "b_bad_s4");
    run_cmd(1'b1, 3, 8'h92, 8'h00, 1'b0, 4, 1, "b_store_s3");
    for (int i = 0; i < 25; i++) begin
      run_cmd(1'($urandom), int'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
              (i != 24) && ($urandom_range(0, 1) == 1), 4, 1, $sformatf("rand_b%0d", i));
    end
    check("b_final/idle", IDLE_V);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
